// File: rtl/cnn_pkg.sv
// Shared constants, types and the byte->Q pixel scaling used by the CNN ingest path.
package cnn_pkg;

    localparam int          DATA_WIDTH     = 16;
    localparam int          FRAC_BITS      = 7;
    localparam int          IMG_SIZE       = 28;
    localparam int          NPIX           = IMG_SIZE * IMG_SIZE;
    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
    localparam int          TIMEOUT_CYCLES = 34_720;

    typedef logic [$clog2(NPIX)-1:0] if_addr_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_BUSY = 2'd1,
        ERR_CSUM = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PIXELS = 2'd1,
        ST_CHECK  = 2'd2
    } ldr_state_t;

    // q = (byte * 2^frac + 127) / 255, truncated; maps 0..255 onto 0..2^frac
    function automatic int unsigned pix_to_q(input logic [7:0] b, input int unsigned frac);
        int unsigned num;
        num = (32'(b) << frac) + 32'd127;
        return num / 32'd255;
    endfunction

endpackage

// File: rtl/pix_q_lut.sv
// 256-entry byte->Q(FRAC_BITS) ROM, built from constants so it folds into a LUT/ROM.
module pix_q_lut
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = cnn_pkg::FRAC_BITS
) (
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] rom [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = DATA_WIDTH'(pix_to_q(8'(i), FRAC_BITS));
    end

    assign q_o = rom[byte_i];

endmodule

// File: rtl/uart_frame_loader.sv
// Frames the uart_rx byte stream (SYNC, pixels, checksum) into IFMAP port A writes and
// reports good frames / aborts to the controller.
module uart_frame_loader
    import cnn_pkg::*;
#(
    parameter int         DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
    parameter int         FRAC_BITS      = cnn_pkg::FRAC_BITS,
    parameter int         IMG_SIZE       = cnn_pkg::IMG_SIZE,
    parameter logic [7:0] SYNC_BYTE      = cnn_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = cnn_pkg::TIMEOUT_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  rx_dv,
    input  logic [7:0]                            rx_byte,
    input  logic                                  pipe_busy,
    output logic                                  if_we,
    output logic [$clog2(IMG_SIZE*IMG_SIZE)-1:0]  if_addr,
    output logic [DATA_WIDTH-1:0]                 if_din,
    output logic                                  frame_loaded,
    output logic                                  frame_err,
    output logic [1:0]                            err_code,
    output logic [15:0]                           frames_ok
);

    localparam int N_PIX  = IMG_SIZE * IMG_SIZE;
    localparam int ADDR_W = $clog2(N_PIX);
    localparam int CNT_W  = $clog2(N_PIX + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);

    ldr_state_t             state_q, state_d;
    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [7:0]             csum_q, csum_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  din_q, din_d;
    logic                   loaded_q, loaded_d;
    logic                   err_q, err_d;
    err_code_t              code_q, code_d;
    logic [15:0]            fok_q, fok_d;

    logic [DATA_WIDTH-1:0]  pix_q;
    logic                   is_sync;
    logic                   tmo_hit;
    logic                   last_pix;

    pix_q_lut #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_lut (
        .byte_i (rx_byte),
        .q_o    (pix_q)
    );

    assign is_sync  = rx_dv && (rx_byte == SYNC_BYTE);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit  = !rx_dv && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_pix = (pix_cnt_q == CNT_W'(N_PIX - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pix_cnt_q <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
            fok_q     <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            code_q    <= code_d;
            fok_q     <= fok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (is_sync && !pipe_busy) state_d = ST_PIXELS;
            ST_PIXELS: begin
                if (rx_dv && last_pix) state_d = ST_CHECK;
                else if (tmo_hit)      state_d = ST_IDLE;
            end
            ST_CHECK:  if (rx_dv || tmo_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        loaded_d  = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        fok_d     = fok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (is_sync && pipe_busy) begin
                    err_d  = 1'b1;
                    code_d = ERR_BUSY;
                end else if (is_sync) begin
                    pix_cnt_d = '0;
                    csum_d    = '0;
                    tmo_d     = '0;
                end
            end
            ST_PIXELS: begin
                if (rx_dv) begin
                    we_d      = 1'b1;
                    addr_d    = pix_cnt_q[ADDR_W-1:0];
                    din_d     = pix_q;
                    csum_d    = csum_q + rx_byte;
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    tmo_d     = '0;
                end else if (tmo_hit) begin
                    err_d  = 1'b1;
                    code_d = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (rx_dv) begin
                    tmo_d = '0;
                    if (rx_byte == csum_q) begin
                        loaded_d = 1'b1;
                        fok_d    = fok_q + 16'd1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                end else if (tmo_hit) begin
                    err_d  = 1'b1;
                    code_d = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign if_we        = we_q;
    assign if_addr      = addr_q;
    assign if_din       = din_q;
    assign frame_loaded = loaded_q;
    assign frame_err    = err_q;
    assign err_code     = code_q;
    assign frames_ok    = fok_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: drivers push expected IFMAP writes and
// frame pulses; a negedge monitor pops and compares whenever the DUT emits one.
module tb_uart_frame_loader;

    localparam int         T_OUT = 34_720;
    localparam int         NPIX  = 784;
    localparam logic [7:0] CSUM  = 8'hF8;   // sum of (i%256), i<784, = 98040 mod 256

    logic        clk, reset_n, rx_dv, pipe_busy;
    logic [7:0]  rx_byte;
    logic        if_we, frame_loaded, frame_err;
    logic [9:0]  if_addr;
    logic [15:0] if_din;
    logic [1:0]  err_code;
    logic [15:0] frames_ok;

    uart_frame_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_dv        (rx_dv),
        .rx_byte      (rx_byte),
        .pipe_busy    (pipe_busy),
        .if_we        (if_we),
        .if_addr      (if_addr),
        .if_din       (if_din),
        .frame_loaded (frame_loaded),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .frames_ok    (frames_ok)
    );

    typedef struct {
        int     kind;   // 0 write, 1 frame_loaded, 2 frame_err
        int     addr;
        int     din;
        int     err;
        int     fok;
        longint cyc;
    } ev_t;

    ev_t    exp_q[$];
    ev_t    e;
    int     n_total = 0, n_pass = 0;
    longint cyc = 0, last_cyc = 0;
    int     err_m = 0, fok_m = 0;
    int     seen_din [256];
    int     mk, nev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic int qref(input int b);
        return int'($floor((real'(b) * 128.0 + 127.0) / 255.0));
    endfunction

    // Monitor: one event per cycle at most, compared against the head of the queue.
    always @(negedge clk) begin
        if (reset_n && (if_we || frame_loaded || frame_err)) begin
            nev = int'(if_we) + int'(frame_loaded) + int'(frame_err);
            mk  = if_we ? 0 : (frame_loaded ? 1 : 2);
            chk("one_event_per_cycle", nev, 1);
            if (if_we && if_addr < 10'd256) seen_din[if_addr] = int'(if_din);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got kind %0d addr %0d, expected no event (cycle %0d)",
                         mk, if_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", mk, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == 0) begin
                    chk("if_addr", if_addr, e.addr);
                    chk("if_din", if_din, e.din);
                end
                chk("err_code", err_code, e.err);
                chk("frames_ok", frames_ok, e.fok);
            end
        end
    end

    task automatic push(input int kind, input int addr, input int din);
        ev_t x;
        x.kind = kind; x.addr = addr; x.din = din;
        x.err = err_m; x.fok = fok_m; x.cyc = last_cyc + 1;
        exp_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_byte = b; last_cyc = cyc;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_pix(input int i);
        send_byte(8'(i % 256));
        push(0, i, qref(i % 256));
    endtask

    task automatic send_frame(input bit good);
        send_byte(8'hA5);
        for (int i = 0; i < NPIX; i++) send_pix(i);
        if (good) begin
            send_byte(CSUM);
            fok_m = (fok_m + 1) & 16'hFFFF;
            push(1, 0, 0);
        end else begin
            send_byte(CSUM + 8'd1);
            err_m = 2;
            push(2, 0, 0);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        chk({"drain_", nm}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_if_we"}, if_we, 0);
        chk({nm, "_if_addr"}, if_addr, 0);
        chk({nm, "_if_din"}, if_din, 0);
        chk({nm, "_frame_loaded"}, frame_loaded, 0);
        chk({nm, "_frame_err"}, frame_err, 0);
        chk({nm, "_err_code"}, err_code, 0);
        chk({nm, "_frames_ok"}, frames_ok, 0);
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; pipe_busy = 1'b0;
        for (int i = 0; i < 256; i++) seen_din[i] = -1;
        #23;
        chk_zero("reset");
        @(negedge clk) reset_n = 1'b1;

        // 1: good frame, spot-check the scaling endpoints
        send_frame(1'b1);
        drain("good_frame");
        chk("din_of_0", seen_din[0], 0);
        chk("din_of_128", seen_din[128], 64);
        chk("din_of_255", seen_din[255], 128);

        // 2: checksum off by one
        send_frame(1'b0);
        drain("bad_csum");

        // 3: garbage in IDLE is dropped silently
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        send_frame(1'b1);
        drain("garbage");

        // 4: SYNC while busy is rejected, later SYNC accepted
        pipe_busy = 1'b1;
        send_byte(8'hA5);
        err_m = 1;
        push(2, 0, 0);
        send_byte(8'h33);
        pipe_busy = 1'b0;
        send_frame(1'b1);
        drain("busy");

        // 5: stall after 100 pixels; error lands exactly T_OUT cycles after the last byte
        send_byte(8'hA5);
        for (int i = 0; i < 100; i++) send_pix(i);
        err_m = 3;
        last_cyc = last_cyc + T_OUT;
        push(2, 0, 0);
        repeat (T_OUT + 20) @(posedge clk);
        drain("timeout");
        send_frame(1'b1);
        drain("after_timeout");

        // 6: async reset while the write for pixel 400 is on the port
        send_byte(8'hA5);
        for (int i = 0; i <= 400; i++) send_pix(i);
        #6 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        fok_m = 0; err_m = 0;
        send_frame(1'b1);
        drain("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
